muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 16 +
 rtl/muldiv_edge.sv | 28 ++
 rtl/muldiv_ctrl.sv | 139 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl shared definitions: FSM state encoding, operation codes
// and the default WAIT watchdog limit.
package muldiv_ctrl_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LAUNCH  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_ERR     = 3'd4;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int TIMEOUT_DEF = 48;

endpackage

// File: rtl/muldiv_edge.sv
// Selects the done input of the active unit and flags its 0->1 edge.
// Ports: clk, Reset (async, active-low), op, mult_out, div_out -> rise.
module muldiv_edge
   import muldiv_ctrl_pkg::*;
(
   input  logic clk,
   input  logic Reset,
   input  logic op,
   input  logic mult_out,
   input  logic div_out,
   output logic rise
);

   logic sel;
   logic prev;

   assign sel = (op == OP_DIV) ? div_out : mult_out;

   // History is refreshed every cycle, including LAUNCH, so a done
   // level that is already high when WAIT starts never reads as an edge.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) prev <= 1'b0;
      else        prev <= sel;
   end

   assign rise = sel & ~prev;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: launches the external unit, waits for
// its done edge and captures the result. Optional WAIT watchdog is built
// only with MULDIV_TIMEOUT_EN defined.
// Ports: clk, Reset (async, active-low); Start, Op, A, B request;
// HiWrite, LoWrite, WrData direct HI/LO write; Busy, Done, DivZero,
// Timeout status; HI, LO results; OpA, OpB latched operands;
// MultIn/MultOut/MultHigh/MultLow and DivIn/DivOut/DivHigh/DivLow units.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic        Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HiWrite,
   input  logic        LoWrite,
   input  logic [31:0] WrData,
   output logic        Busy,
   output logic        Done,
   output logic        DivZero,
   output logic        Timeout,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] OpA,
   output logic [31:0] OpB,
   output logic        MultIn,
   input  logic        MultOut,
   input  logic [31:0] MultHigh,
   input  logic [31:0] MultLow,
   output logic        DivIn,
   input  logic        DivOut,
   input  logic [31:0] DivHigh,
   input  logic [31:0] DivLow
);

   logic [2:0] state;
   logic [2:0] nxt;
   logic       op_q;
   logic       rise;
   logic       expire;
   logic       start_ok;
   logic       idle;

   assign idle     = (state == S_IDLE);
   assign start_ok = idle & Start;

   muldiv_edge u_edge (
      .clk      (clk),
      .Reset    (Reset),
      .op       (op_q),
      .mult_out (MultOut),
      .div_out  (DivOut),
      .rise     (rise)
   );

`ifdef MULDIV_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;
   logic          timeout_q;

   assign expire = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == S_WAIT) cnt <= cnt + 1'b1;
         else                 cnt <= '0;
         if (start_ok)
            timeout_q <= 1'b0;
         else if (state == S_WAIT && expire && !rise)
            timeout_q <= 1'b1;
      end
   end

   assign Timeout = timeout_q;
`else
   // No watchdog: WAIT holds until the unit answers.
   assign expire  = 1'b0;
   assign Timeout = 1'b0 & (TIMEOUT > 0);
`endif

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: begin
            if (Start)
               nxt = (Op == OP_DIV && B == '0) ? S_ERR : S_LAUNCH;
         end
         S_LAUNCH: nxt = S_WAIT;
         S_WAIT: begin
            if (rise)        nxt = S_CAPTURE;
            else if (expire) nxt = S_IDLE;
         end
         S_CAPTURE: nxt = S_IDLE;
         S_ERR:     nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
         op_q  <= OP_MULT;
         OpA   <= '0;
         OpB   <= '0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         state <= nxt;
         if (start_ok) begin
            op_q <= Op;
            OpA  <= A;
            OpB  <= B;
         end
         if (idle && HiWrite)
            HI <= WrData;
         else if (state == S_CAPTURE)
            HI <= (op_q == OP_DIV) ? DivHigh : MultHigh;
         if (idle && LoWrite)
            LO <= WrData;
         else if (state == S_CAPTURE)
            LO <= (op_q == OP_DIV) ? DivLow : MultLow;
      end
   end

   assign Busy    = ~idle;
   assign Done    = (state == S_CAPTURE);
   assign DivZero = (state == S_ERR);
   assign MultIn  = (state == S_LAUNCH) & (op_q == OP_MULT);
   assign DivIn   = (state == S_LAUNCH) & (op_q == OP_DIV);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural mult/div units.
// Build with MULDIV_TIMEOUT_EN to exercise the WAIT watchdog.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        Reset;
   logic        Start, Op, HiWrite, LoWrite;
   logic [31:0] A, B, WrData;
   logic        Busy, Done, DivZero, Timeout;
   logic [31:0] HI, LO, OpA, OpB;
   logic        MultIn, MultOut, DivIn, DivOut;
   logic [31:0] MultHigh, MultLow, DivHigh, DivLow;

   muldiv_ctrl dut (
      .clk(clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiWrite(HiWrite), .LoWrite(LoWrite), .WrData(WrData),
      .Busy(Busy), .Done(Done), .DivZero(DivZero), .Timeout(Timeout),
      .HI(HI), .LO(LO), .OpA(OpA), .OpB(OpB),
      .MultIn(MultIn), .MultOut(MultOut),
      .MultHigh(MultHigh), .MultLow(MultLow),
      .DivIn(DivIn), .DivOut(DivOut),
      .DivHigh(DivHigh), .DivLow(DivLow)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nbad = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Behavioural units
   logic        man_en = 1'b0, man_out = 1'b0;
   logic [31:0] man_hi = '0, man_lo = '0;
   logic        m_lvl = 1'b0, d_lvl = 1'b0;
   logic        m_run = 1'b0, d_run = 1'b0;
   int          m_dly = 0, d_dly = 0;
   logic [31:0] m_hi = '0, m_lo = '0, d_hi = '1, d_lo = '1;
   longint      prod;

   always @(posedge clk) begin
      if (MultIn) begin
         prod = longint'($signed(OpA)) * longint'($signed(OpB));
         m_hi  <= prod[63:32];
         m_lo  <= prod[31:0];
         m_lvl <= 1'b0;
         m_run <= 1'b1;
         m_dly <= $urandom_range(0, 4);
      end else if (m_run) begin
         if (m_dly == 0) begin
            m_lvl <= 1'b1;
            m_run <= 1'b0;
         end else m_dly <= m_dly - 1;
      end
      if (DivIn) begin
         if (OpB != 0) begin
            d_hi <= $signed(OpA) % $signed(OpB);
            d_lo <= $signed(OpA) / $signed(OpB);
         end
         d_lvl <= 1'b0;
         d_run <= 1'b1;
         d_dly <= $urandom_range(0, 6);
      end else if (d_run) begin
         if (d_dly == 0) begin
            d_lvl <= 1'b1;
            d_run <= 1'b0;
         end else d_dly <= d_dly - 1;
      end
   end

   assign MultOut  = man_en ? man_out : m_lvl;
   assign MultHigh = man_en ? man_hi  : m_hi;
   assign MultLow  = man_en ? man_lo  : m_lo;
   assign DivOut   = man_en ? man_out : d_lvl;
   assign DivHigh  = man_en ? man_hi  : d_hi;
   assign DivLow   = man_en ? man_lo  : d_lo;

   // Reference model and scoreboard
   typedef struct {
      logic        zero;
      logic        is_div;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mhi = '0, mlo = '0;
   int          done_seen = 0;

   function automatic exp_t model(logic op, logic [31:0] a, logic [31:0] b);
      exp_t   e;
      longint p;
      int     sa, sb;
      sa = a;
      sb = b;
      e.is_div = op;
      e.zero   = op && (b == 0);
      if (e.zero) begin
         e.hi = mhi;
         e.lo = mlo;
      end else if (op) begin
         e.hi = sa % sb;
         e.lo = sa / sb;
      end else begin
         p = longint'(sa) * longint'(sb);
         e.hi = p[63:32];
         e.lo = p[31:0];
      end
      return e;
   endfunction

   // Monitor
   int   mcnt = 0, dcnt = 0;
   logic pend = 1'b0;
   exp_t pe;

   always @(negedge clk) begin
      exp_t e;
      if (pend) begin
         chk("hi_result", HI, pe.hi);
         chk("lo_result", LO, pe.lo);
         pend = 1'b0;
      end
      if (!Busy) begin
         mcnt = 0;
         dcnt = 0;
      end
      if (MultIn) mcnt++;
      if (DivIn)  dcnt++;
      if (Done && DivZero) chk("done_and_divzero", 1, 0);
      if (Done) done_seen++;
      if (Done || DivZero) begin
         if (q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
         end else begin
            e = q.pop_front();
            chk("kind_divzero", DivZero, e.zero);
            chk("mult_pulses", mcnt, (!e.is_div && !e.zero) ? 1 : 0);
            chk("div_pulses", dcnt, (e.is_div && !e.zero) ? 1 : 0);
            pe   = e;
            pend = 1'b1;
         end
      end
   end

   // Stimulus helpers
   task automatic wait_idle();
      int n = 0;
      while (Busy !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("wait_idle_bound", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic drive_start(logic op, logic [31:0] a, logic [31:0] b);
      @(negedge clk);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(negedge clk);
      Start = 1'b0;
   endtask

   task automatic do_op(logic op, logic [31:0] a, logic [31:0] b,
                        logic hw, logic lw, logic [31:0] wd, logic bw);
      exp_t e;
      wait_idle();
      @(negedge clk);
      Start   = 1'b1;
      Op      = op;
      A       = a;
      B       = b;
      HiWrite = hw;
      LoWrite = lw;
      WrData  = wd;
      if (hw) mhi = wd;
      if (lw) mlo = wd;
      e = model(op, a, b);
      q.push_back(e);
      @(negedge clk);
      Start   = 1'b0;
      HiWrite = bw;
      LoWrite = bw;
      WrData  = $urandom;
      if (e.zero) chk("divzero_latency", DivZero, 1);
      else if (op) chk("divin_latency", DivIn, 1);
      else chk("multin_latency", MultIn, 1);
      @(negedge clk);
      HiWrite = 1'b0;
      LoWrite = 1'b0;
      wait_idle();
      mhi = e.hi;
      mlo = e.lo;
   endtask

   initial begin
      int   d0;
      logic op;
      logic [31:0] a, b;
      Reset = 1'b0;
      Start = 1'b0; Op = 1'b0; A = '0; B = '0;
      HiWrite = 1'b0; LoWrite = 1'b0; WrData = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_divzero", DivZero, 0);
      chk("rst_timeout", Timeout, 0);
      chk("rst_multin", MultIn, 0);
      chk("rst_divin", DivIn, 0);
      chk("rst_hi", HI, 0);
      chk("rst_lo", LO, 0);
      chk("rst_opa", OpA, 0);
      chk("rst_opb", OpB, 0);
      Reset = 1'b1;
      repeat (2) @(negedge clk);

      do_op(1'b0, 32'd7, -32'sd3, 1'b0, 1'b0, '0, 1'b0);
      chk("mult_7x-3_hi", HI, 32'hFFFF_FFFF);
      chk("mult_7x-3_lo", LO, 32'hFFFF_FFEB);
      do_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, '0, 1'b1);
      chk("div_100_7_hi", HI, 32'd2);
      chk("div_100_7_lo", LO, 32'd14);
      do_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, '0, 1'b0);
      chk("div0_keep_hi", HI, 32'd2);
      chk("div0_keep_lo", LO, 32'd14);
      do_op(1'b1, 32'd9, 32'd0, 1'b1, 1'b1, 32'hA5A5_5A5A, 1'b0);
      chk("mt_with_start_hi", HI, 32'hA5A5_5A5A);

      // Done level already high at launch; Start in WAIT ignored
      wait_idle();
      man_en  = 1'b1;
      man_out = 1'b1;
      man_hi  = 32'hFFFF_FFFF;
      man_lo  = 32'hFFFF_FFC9;
      q.push_back(model(1'b0, 32'd11, -32'sd5));
      d0 = done_seen;
      drive_start(1'b0, 32'd11, -32'sd5);
      repeat (4) @(negedge clk);
      drive_start(1'b1, 32'd1, 32'd0);
      repeat (3) @(negedge clk);
      chk("held_level_no_done", done_seen, d0);
      chk("wait_start_opa", OpA, 32'd11);
      chk("wait_busy", Busy, 1);
      man_out = 1'b0;
      repeat (2) @(negedge clk);
      man_out = 1'b1;
      wait_idle();
      chk("reraise_done", done_seen, d0 + 1);
      mhi = 32'hFFFF_FFFF;
      mlo = 32'hFFFF_FFC9;

      // Unit that never answers
      man_out = 1'b0;
      d0 = done_seen;
      drive_start(1'b0, 32'd3, 32'd3);
      repeat (40) @(negedge clk);
      chk("stall_busy_mid", Busy, 1);
      repeat (20) @(negedge clk);
`ifdef MULDIV_TIMEOUT_EN
      chk("timeout_flag", Timeout, 1);
      chk("timeout_busy", Busy, 0);
      chk("timeout_no_done", done_seen, d0);
      chk("timeout_hi_kept", HI, mhi);
      man_en = 1'b0;
      do_op(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, '0, 1'b0);
      chk("timeout_cleared", Timeout, 0);
      man_en  = 1'b1;
      man_out = 1'b0;
      drive_start(1'b1, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
`else
      chk("no_timeout_busy", Busy, 1);
      chk("no_timeout_flag", Timeout, 0);
`endif

      // Reset during WAIT, then a late done edge
      d0 = done_seen;
      Reset = 1'b0;
      @(negedge clk);
      Reset = 1'b1;
      mhi = '0;
      mlo = '0;
      @(negedge clk);
      man_out = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_wait_no_done", done_seen, d0);
      chk("rst_wait_busy", Busy, 0);
      chk("rst_wait_hi", HI, 0);
      chk("rst_wait_lo", LO, 0);
      man_en  = 1'b0;
      man_out = 1'b0;

      for (int i = 0; i < 40; i++) begin
         op = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 20)) - 32'd10;
         if (op && $urandom_range(0, 7) == 0) b = '0;
         if (op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         do_op(op, a, b, 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0), $urandom,
               1'($urandom_range(0, 1)));
      end
      chk("queue_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
